// File: rtl/au_if.sv
// Operation request / result bundle between the microprogram sequencer and au_engine.
// The sequencer side is the master, the arithmetic unit is the slave.
interface au_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] result;
    logic             done;
    logic             busy;
    logic             ovf;
    logic             dz;

    modport master (
        output start, op, op_a, op_b,
        input  result, done, busy, ovf, dz
    );

    modport slave (
        input  start, op, op_a, op_b,
        output result, done, busy, ovf, dz
    );
endinterface

// File: rtl/au_engine.sv
// Signed fixed-point ADD/SUB/MUL/DIV unit; MUL and DIV iterate one result bit per cycle.
// Define AU_SATURATE_EN to clamp overflowed results instead of wrapping them.
module au_engine #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8
) (
    input  logic clk,
    input  logic rst,
    au_if.slave  bus
);
    localparam int MW = 2 * WIDTH;
    localparam int DW = WIDTH + FRAC;
    localparam int CW = $clog2(DW + 1);

    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    localparam logic [WIDTH-1:0] POS_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] NEG_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [MW-1:0]    MAG_LIM = MW'(1) << (WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t           state_reg, state_next;
    logic [1:0]       op_reg;
    logic [WIDTH-1:0] a_reg, b_reg;
    logic [CW-1:0]    cnt_reg;
    logic [MW-1:0]    work_reg;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] result_reg;
    logic             done_reg, ovf_reg, dz_reg;

    logic             accept;
    logic [WIDTH-1:0] in_mag_a, in_mag_b, mag_a, mag_b;
    logic [WIDTH:0]   mul_sum;
    logic [MW-1:0]    mul_next;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_sub, div_rem_next;
    logic [MW-1:0]    div_q_next;
    logic [WIDTH:0]   as_ext_a, as_ext_b, as_sum;
    logic             it_sign;
    logic [MW-1:0]    it_mag;
    logic [WIDTH-1:0] fin_result;
    logic             fin_ovf, fin_dz;

    // A start seen in the done cycle belongs to the instruction being released, so drop it.
    always_comb begin
        accept   = bus.start && (state_reg == IDLE) && !done_reg;
        in_mag_a = bus.op_a[WIDTH-1] ? -bus.op_a : bus.op_a;
        in_mag_b = bus.op_b[WIDTH-1] ? -bus.op_b : bus.op_b;
        mag_a    = a_reg[WIDTH-1] ? -a_reg : a_reg;
        mag_b    = b_reg[WIDTH-1] ? -b_reg : b_reg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (bus.op == OP_MUL || (bus.op == OP_DIV && bus.op_b != '0)) begin
                        state_next = RUN;
                    end else begin
                        state_next = FIN;
                    end
                end
            end
            RUN: begin
                if (cnt_reg == CW'(1)) begin
                    state_next = FIN;
                end
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // MUL: work_reg is {partial product, remaining multiplier bits}, shifted right each step.
    // DIV: work_reg shifts the dividend out of its top and the quotient bits into its bottom.
    always_comb begin
        mul_sum      = {1'b0, work_reg[MW-1:WIDTH]} + (work_reg[0] ? {1'b0, mag_a} : '0);
        mul_next     = {mul_sum, work_reg[WIDTH-1:1]};
        div_shift    = {rem_reg, work_reg[DW-1]};
        div_ge       = div_shift >= {1'b0, mag_b};
        div_sub      = div_shift[WIDTH-1:0] - mag_b;
        div_rem_next = div_ge ? div_sub : div_shift[WIDTH-1:0];
        div_q_next   = {work_reg[MW-2:0], div_ge};
    end

    always_comb begin
        as_ext_a = {a_reg[WIDTH-1], a_reg};
        as_ext_b = {b_reg[WIDTH-1], b_reg};
        as_sum   = op_reg[0] ? (as_ext_a - as_ext_b) : (as_ext_a + as_ext_b);
        it_sign  = a_reg[WIDTH-1] ^ b_reg[WIDTH-1];
        it_mag   = op_reg[0] ? MW'(work_reg[DW-1:0]) : (work_reg >> FRAC);

        fin_dz     = 1'b0;
        fin_ovf    = as_sum[WIDTH] ^ as_sum[WIDTH-1];
        fin_result = as_sum[WIDTH-1:0];
        if (op_reg == OP_DIV && b_reg == '0) begin
            fin_dz     = 1'b1;
            fin_ovf    = 1'b0;
            fin_result = a_reg[WIDTH-1] ? NEG_MIN : POS_MAX;
        end else if (op_reg[1]) begin
            // A negative result may reach exactly 2^(WIDTH-1) in magnitude; a positive one may not.
            fin_ovf    = it_sign ? (it_mag > MAG_LIM) : (it_mag >= MAG_LIM);
            fin_result = it_sign ? -it_mag[WIDTH-1:0] : it_mag[WIDTH-1:0];
        end
`ifdef AU_SATURATE_EN
        if (fin_ovf) begin
            fin_result = (op_reg[1] ? it_sign : as_sum[WIDTH]) ? NEG_MIN : POS_MAX;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_reg     <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            cnt_reg    <= '0;
            work_reg   <= '0;
            rem_reg    <= '0;
            result_reg <= '0;
            done_reg   <= 1'b0;
            ovf_reg    <= 1'b0;
            dz_reg     <= 1'b0;
        end else begin
            done_reg <= (state_reg == FIN);
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        op_reg  <= bus.op;
                        a_reg   <= bus.op_a;
                        b_reg   <= bus.op_b;
                        ovf_reg <= 1'b0;
                        dz_reg  <= 1'b0;
                        rem_reg <= '0;
                        if (bus.op == OP_MUL) begin
                            cnt_reg  <= CW'(WIDTH);
                            work_reg <= MW'(in_mag_b);
                        end else begin
                            cnt_reg  <= CW'(DW);
                            work_reg <= MW'({in_mag_a, {FRAC{1'b0}}});
                        end
                    end
                end
                RUN: begin
                    cnt_reg <= cnt_reg - CW'(1);
                    if (op_reg[0]) begin
                        work_reg <= div_q_next;
                        rem_reg  <= div_rem_next;
                    end else begin
                        work_reg <= mul_next;
                    end
                end
                FIN: begin
                    result_reg <= fin_result;
                    ovf_reg    <= fin_ovf;
                    dz_reg     <= fin_dz;
                end
                default: ;
            endcase
        end
    end

    assign bus.result = result_reg;
    assign bus.done   = done_reg;
    assign bus.busy   = (state_reg != IDLE);
    assign bus.ovf    = ovf_reg;
    assign bus.dz     = dz_reg;
endmodule

// File: tb/tb_au_engine.sv
// Self-checking bench for au_engine: directed vector table, hand-written corner sequences,
// and random operations checked against an integer-arithmetic model of the Q8.8 rules.
module tb_au_engine;
    localparam bit SAT =
`ifdef AU_SATURATE_EN
        1'b1;
`else
        1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    au_if #(.WIDTH(16)) bus();
    au_engine #(.WIDTH(16), .FRAC(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        ovf;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic longint iabs(input longint v);
        return (v < 0) ? -v : v;
    endfunction

    // Reference model: true integer result of the fixed-point operation, then range rules.
    function automatic void model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] r, output logic o, output logic z,
                                  output int lat);
        longint sa, sb, t, mag;
        bit     neg;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        z   = 1'b0;
        o   = 1'b0;
        neg = 1'b0;
        if (op < 2) begin
            t   = (op == 0) ? sa + sb : sa - sb;
            o   = (t > 32767) || (t < -32768);
            neg = (t < 0);
            lat = 1;
        end else if (op == 3 && sb == 0) begin
            z   = 1'b1;
            t   = (sa >= 0) ? 32767 : -32768;
            lat = 1;
        end else begin
            mag = (op == 2) ? (iabs(sa) * iabs(sb)) / 256 : (iabs(sa) * 256) / iabs(sb);
            neg = (sa < 0) != (sb < 0);
            o   = neg ? (mag > 32768) : (mag >= 32768);
            t   = neg ? -mag : mag;
            lat = (op == 2) ? 17 : 25;
        end
        r = t[15:0];
        if (SAT && o) r = neg ? 16'h8000 : 16'h7FFF;
    endfunction

    task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        bus.op    = op;
        bus.op_a  = a;
        bus.op_b  = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op    = 2'($urandom);
        bus.op_a  = 16'($urandom);
        bus.op_b  = 16'($urandom);
    endtask

    // Called 1 time unit after the accepting edge; returns edges until done (-1 on timeout).
    task automatic wait_done(output int lat, output logic busy_ok);
        lat     = -1;
        busy_ok = (bus.busy === 1'b1);
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) begin
                lat = k;
                if (bus.busy !== 1'b0) busy_ok = 1'b0;
                break;
            end
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] res, input logic ovf,
                          input logic dz, input int lat_exp);
        int   lat;
        logic bok;
        issue(op, a, b);
        wait_done(lat, bok);
        $display("%s op=%0d a=%h b=%h result=%h ovf=%b dz=%b lat=%0d", tag, op, a, b,
                 bus.result, bus.ovf, bus.dz, lat);
        check({tag, ".lat"}, lat, lat_exp);
        check({tag, ".result"}, bus.result, res);
        check({tag, ".ovf"}, bus.ovf, ovf);
        check({tag, ".dz"}, bus.dz, dz);
        check({tag, ".busy"}, bok, 1'b1);
        @(posedge clk);
        #1;
        check({tag, ".done_pulse"}, bus.done, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic        bok;
        logic        seen;
        logic [1:0]  rop;
        logic [15:0] ra, rb, rres;
        logic        rovf, rdz;
        int          rlat;

        vecs[0]  = '{2'd0, 16'h0180, 16'h0200, 16'h0380, 1'b0, 1'b0, 1};
        vecs[1]  = '{2'd1, 16'h0100, 16'h0300, 16'hFE00, 1'b0, 1'b0, 1};
        vecs[2]  = '{2'd2, 16'h0180, 16'hFE00, 16'hFD00, 1'b0, 1'b0, 17};
        vecs[3]  = '{2'd3, 16'h0300, 16'h0200, 16'h0180, 1'b0, 1'b0, 25};
        vecs[4]  = '{2'd3, 16'h0100, 16'h0000, 16'h7FFF, 1'b0, 1'b1, 1};
        vecs[5]  = '{2'd0, 16'h7F00, 16'h0200, SAT ? 16'h7FFF : 16'h8100, 1'b1, 1'b0, 1};
        vecs[6]  = '{2'd1, 16'h8000, 16'h0001, SAT ? 16'h8000 : 16'h7FFF, 1'b1, 1'b0, 1};
        vecs[7]  = '{2'd3, 16'hFF00, 16'h0000, 16'h8000, 1'b0, 1'b1, 1};
        vecs[8]  = '{2'd2, 16'h8000, 16'h0100, 16'h8000, 1'b0, 1'b0, 17};
        vecs[9]  = '{2'd2, 16'h8000, 16'hFF00, SAT ? 16'h7FFF : 16'h8000, 1'b1, 1'b0, 17};
        vecs[10] = '{2'd3, 16'h7FFF, 16'h0001, SAT ? 16'h7FFF : 16'hFF00, 1'b1, 1'b0, 25};
        vecs[11] = '{2'd3, 16'hFD00, 16'h0200, 16'hFE80, 1'b0, 1'b0, 25};
        vecs[12] = '{2'd2, 16'hFFFF, 16'h0080, 16'h0000, 1'b0, 1'b0, 17};
        vecs[13] = '{2'd3, 16'h0001, 16'h0300, 16'h0000, 1'b0, 1'b0, 25};

        rst      = 1'b1;
        bus.start = 1'b0;
        bus.op   = 2'd0;
        bus.op_a = 16'h0000;
        bus.op_b = 16'h0000;
        #1;
        check("reset.result", bus.result, 16'h0000);
        check("reset.done", bus.done, 1'b0);
        check("reset.busy", bus.busy, 1'b0);
        check("reset.ovf", bus.ovf, 1'b0);
        check("reset.dz", bus.dz, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].res, vecs[i].ovf, vecs[i].dz, vecs[i].lat);
        end

        // ADD request ten cycles into a MUL must not disturb it.
        issue(2'd2, 16'h0180, 16'hFE00);
        repeat (9) @(posedge clk);
        @(negedge clk);
        bus.op    = 2'd0;
        bus.op_a  = 16'h0001;
        bus.op_b  = 16'h0001;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(lat, bok);
        $display("mul_busy_start result=%h lat=%0d", bus.result, lat + 10);
        check("mul_busy_start.lat", lat + 10, 17);
        check("mul_busy_start.result", bus.result, 16'hFD00);
        check("mul_busy_start.busy", bok, 1'b1);
        @(posedge clk);
        #1;
        check("mul_busy_start.done_pulse", bus.done, 1'b0);

        // Reset during a DIV abandons it silently.
        issue(2'd3, 16'h0300, 16'h0200);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("div_rst.busy", bus.busy, 1'b0);
        check("div_rst.done", bus.done, 1'b0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) seen = 1'b1;
        end
        $display("div_rst done_seen=%b", seen);
        check("div_rst.no_done", seen, 1'b0);
        run_op("add_after_rst", 2'd0, 16'h0100, 16'h0200, 16'h0300, 1'b0, 1'b0, 1);

        // Start raised in the done cycle itself is ignored.
        issue(2'd0, 16'h0100, 16'h0100);
        wait_done(lat, bok);
        check("done_cycle.lat", lat, 1);
        bus.op    = 2'd1;
        bus.op_a  = 16'h0500;
        bus.op_b  = 16'h0100;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        $display("done_cycle_start busy=%b result=%h", bus.busy, bus.result);
        check("done_cycle.ignored_busy", bus.busy, 1'b0);
        check("done_cycle.result", bus.result, 16'h0200);
        run_op("after_done_cycle", 2'd1, 16'h0500, 16'h0100, 16'h0400, 1'b0, 1'b0, 1);

        // Asynchronous mid-cycle reset clears non-zero outputs immediately.
        run_op("pre_async_rst", 2'd0, 16'h7F00, 16'h0200, SAT ? 16'h7FFF : 16'h8100, 1'b1, 1'b0, 1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        $display("async_rst result=%h ovf=%b busy=%b", bus.result, bus.ovf, bus.busy);
        check("async_rst.result", bus.result, 16'h0000);
        check("async_rst.ovf", bus.ovf, 1'b0);
        check("async_rst.busy", bus.busy, 1'b0);
        check("async_rst.done", bus.done, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 200; i++) begin
            rop = 2'($urandom);
            case ($urandom_range(0, 7))
                0:       ra = 16'h0000;
                1:       ra = 16'h8000;
                2:       ra = 16'h7FFF;
                3:       ra = 16'($urandom_range(0, 1023)) ^ {16{1'($urandom)}};
                default: ra = 16'($urandom);
            endcase
            case ($urandom_range(0, 7))
                0:       rb = 16'h0000;
                1:       rb = 16'h8000;
                2:       rb = 16'($urandom_range(1, 600)) ^ {16{1'($urandom)}};
                default: rb = 16'($urandom);
            endcase
            model(rop, ra, rb, rres, rovf, rdz, rlat);
            run_op($sformatf("rnd%0d", i), rop, ra, rb, rres, rovf, rdz, rlat);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
